bcd_scan_display: RTL and testbench
===================================

Name: bcd_scan_display

Overview:
- Downstream consumer of the game timer's packed-BCD elapsed-time value.
- Time-multiplexes NUM_DIGITS BCD nibbles onto the board's shared-cathode seven-segment bank.
- Latches new values only at frame boundaries, so the display never shows a torn value.
- Provides anti-ghosting blank time, optional leading-zero suppression, and a dash glyph for non-BCD nibbles.

Parameters:
- NUM_DIGITS, 8, number of digits and anodes; val_in is 4*NUM_DIGITS bits wide.
- DIGIT_CYCLES, 65_000, clock cycles per digit slot (1 ms at 65 MHz); must be at least 2.
- BLANK_CYCLES, 650, cycles at the start of each slot with all anodes off; must be less than DIGIT_CYCLES.

Ports:
- clk_in  input  1  system clock, 65 MHz.
- rst_n_in  input  1  reset.
- val_in  input  4*NUM_DIGITS  packed BCD value; nibble 0 is the rightmost digit.
- val_valid_in  input  1  one-cycle strobe requesting that val_in be displayed.
- blank_zeros_in  input  1  enables leading-zero suppression; sampled with val_in.
- cat_out  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- an_out  output  NUM_DIGITS  active-low, one-hot (or all-off) anode select.
- frame_out  output  1  one-cycle pulse when the digit index wraps to 0.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - an_out = all 1s, cat_out = 7'h7F, frame_out = 0.
  - Slot counter, digit index, staging register, shadow register, blank mask and pending flag all clear to 0.
- Slot counter:
  - Counts 0..DIGIT_CYCLES-1.
  - At the terminal count it wraps to 0 and the digit index advances; index NUM_DIGITS-1 wraps to 0.
  - The wrap into index 0 is the frame boundary; frame_out pulses in that same cycle.
- Value capture (two levels):
  - val_valid_in = 1 copies val_in and blank_zeros_in into staging and sets pending.
  - Multiple strobes within one frame: the last one wins.
  - At the frame boundary, if pending is set: staging moves to shadow, the blank mask is recomputed, and pending clears.
  - Strobe in the same cycle as the boundary: the current val_in goes directly to shadow, and pending is left clear.
- Blank mask:
  - Digit i is blanked when blank_zeros is set and every nibble from i through NUM_DIGITS-1 is 0.
  - Digit 0 is never blanked, so the value 0 displays as "0".
- Outputs are registered and reflect the slot counter and index of the previous cycle (latency 1).
- During counter values 0..BLANK_CYCLES-1: an_out = all 1s, cat_out = 7'h7F.
- Otherwise:
  - an_out has bit [index] = 0 unless the digit is blanked, in which case an_out = all 1s.
  - cat_out is the decoded shadow nibble.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles 10..15 show a dash, 0111111.
- There is no back-pressure; val_valid_in is always accepted.

Optional Feature:
- Macro: SCAN_BLINK_EN.
- When defined:
  - Adds input blink_in (1 bit) and a frame counter.
  - While blink_in = 1, anodes are forced off for 128 of every 256 frames (frame-counter bit 7 = 1).
  - Scanning and capture continue unchanged.
  - When blink_in = 0, the frame counter clears.
- When undefined: no blink_in port, no frame counter, and behaviour is exactly as above.

Decomposition:
- Package display_pkg holds:
  - the seg_t typedef (logic [6:0]);
  - constants SEG_OFF (7'h7F) and SEG_DASH (7'b0111111);
  - the 16-entry active-low glyph table.
- Sub-module bcd_to_seg: combinational nibble-to-seg_t decoder using the package table, instantiated once on the selected nibble.

Test Plan:
- Use NUM_DIGITS=8, DIGIT_CYCLES=8, BLANK_CYCLES=2 for all scenarios.
- Reset: hold rst_n_in low, then release -> an_out=8'hFF, cat_out=7'h7F for 3 cycles; first active digit shows an_out=8'hFE.
- Scan: strobe 32'h00000123 with blank_zeros_in=0, wait one frame -> slots show (FE,0110000), (FD,0100100), (FB,1111001), digits 3..7 show 1000000; frame_out pulses every 64 cycles.
- Leading zero: strobe 32'h00000123 with blank_zeros=1 -> slots 3..7 have an_out=8'hFF. Strobe 32'h0 with blank_zeros=1 -> only digit 0 lit, showing 1000000.
- Tearing: mid-frame, strobe 32'h99, then 32'h45 -> old value remains until the wrap, after which 45 is shown; strobe coincident with frame_out -> applied in that frame.
- Non-BCD: strobe nibble 0 = 4'hA -> digit 0 cat_out=0111111.
- Async reset mid-slot: drop rst_n_in between clock edges -> an_out=8'hFF immediately. After release, the shadow value is 0 and the display shows 0 on all digits (blank_zeros cleared).

Source files
------------

// File: rtl/display_pkg.sv
// Shared seven-segment types and glyph table for the scanned BCD display.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF  = 7'h7F;
    localparam seg_t SEG_DASH = 7'b0111111;

    // Codes 10..15 are not BCD and render as a dash.
    localparam seg_t GLYPH [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, SEG_DASH,   SEG_DASH,
        SEG_DASH,   SEG_DASH,   SEG_DASH,   SEG_DASH
    };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble to active-low seven-segment decoder.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPH[nibble_i];

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed packed-BCD display driver with frame-aligned value capture.
// Optional macro SCAN_BLINK_EN adds blink_in and a frame counter that blanks anodes.
module bcd_scan_display
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 65_000,
    parameter int BLANK_CYCLES = 650
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic                    val_valid_in,
    input  logic                    blank_zeros_in,
`ifdef SCAN_BLINK_EN
    input  logic                    blink_in,
`endif
    output logic [6:0]              cat_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_out
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      stage_q, stage_d;
    logic                  stage_bz_q, stage_bz_d;
    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic                  pend_q, pend_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            cat_q, cat_d;
    logic                  frame_q, frame_d;

    logic                  cnt_last, idx_last, boundary;
    logic                  blink_off;
    logic [6:0]            seg;

    // Digit i is blanked when it and every more-significant nibble are zero; digit 0 stays lit.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [VAL_W-1:0] v, input logic bz);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (v[4*i +: 4] == 4'd0);
            m[i]       = bz & zero_above;
        end
        return m;
    endfunction

    bcd_to_seg u_dec (
        .nibble_i (shadow_q[{idx_q, 2'b00} +: 4]),
        .seg_o    (seg)
    );

    assign cnt_last = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
    assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign boundary = cnt_last & idx_last;

`ifdef SCAN_BLINK_EN
    logic [7:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d = '0;
        if (blink_in) begin
            fcnt_d = boundary ? fcnt_q + 8'd1 : fcnt_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign blink_off = blink_in & fcnt_q[7];
`else
    assign blink_off = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_last) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
        // frame_out is registered, so it is asserted for exactly the cycle that ends in the wrap.
        frame_d = (cnt_d == CNT_W'(DIGIT_CYCLES - 1)) && (idx_d == IDX_W'(NUM_DIGITS - 1));

        stage_d    = stage_q;
        stage_bz_d = stage_bz_q;
        shadow_d   = shadow_q;
        mask_d     = mask_q;
        pend_d     = pend_q;
        if (val_valid_in) begin
            stage_d    = val_in;
            stage_bz_d = blank_zeros_in;
        end
        if (boundary) begin
            if (val_valid_in) begin
                shadow_d = val_in;
                mask_d   = lz_mask(val_in, blank_zeros_in);
            end else if (pend_q) begin
                shadow_d = stage_q;
                mask_d   = lz_mask(stage_q, stage_bz_q);
            end
            pend_d = 1'b0;
        end else if (val_valid_in) begin
            pend_d = 1'b1;
        end

        an_d  = '1;
        cat_d = SEG_OFF;
        if (cnt_q >= CNT_W'(BLANK_CYCLES)) begin
            cat_d = seg;
            if (!mask_q[idx_q] && !blink_off) begin
                an_d[idx_q] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            stage_q    <= '0;
            stage_bz_q <= 1'b0;
            shadow_q   <= '0;
            mask_q     <= '0;
            pend_q     <= 1'b0;
            an_q       <= '1;
            cat_q      <= SEG_OFF;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stage_q    <= stage_d;
            stage_bz_q <= stage_bz_d;
            shadow_q   <= shadow_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            an_q       <= an_d;
            cat_q      <= cat_d;
            frame_q    <= frame_d;
        end
    end

    assign an_out    = an_q;
    assign cat_out   = cat_q;
    assign frame_out = frame_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized and directed bench for bcd_scan_display against a time-position reference model.
module tb_bcd_scan_display;

    localparam int N     = 8;
    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * DC;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [4*N-1:0] val_in;
    logic          val_valid_in;
    logic          blank_zeros_in;
    logic [6:0]    cat_out;
    logic [N-1:0]  an_out;
    logic          frame_out;

    bcd_scan_display #(
        .NUM_DIGITS   (N),
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .val_in         (val_in),
        .val_valid_in   (val_valid_in),
        .blank_zeros_in (blank_zeros_in),
`ifdef SCAN_BLINK_EN
        .blink_in       (1'b0),
`endif
        .cat_out        (cat_out),
        .an_out         (an_out),
        .frame_out      (frame_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: position = clock edges since reset; displayed value and pending request.
    int          pos;
    logic [31:0] m_shadow, m_stage;
    logic        m_bz, m_stage_bz, m_pend;
    logic [7:0]  exp_an;
    logic [6:0]  exp_cat;
    logic        exp_frame;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (pos %0d)", tag, obs, exp, pos);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic bit is_blanked(input int dig);
        return m_bz && (dig > 0) && ((m_shadow >> (4 * dig)) == 32'd0);
    endfunction

    function automatic bit at_wrap(input int p);
        return (p % FRAME) == FRAME - 1;
    endfunction

    task automatic model_reset();
        pos        = 0;
        m_shadow   = '0;
        m_stage    = '0;
        m_bz       = 1'b0;
        m_stage_bz = 1'b0;
        m_pend     = 1'b0;
        exp_an     = 8'hFF;
        exp_cat    = 7'h7F;
        exp_frame  = 1'b0;
    endtask

    task automatic model_edge(input logic vv, input logic [31:0] v, input logic bz);
        int slot_t = pos % DC;
        int dig    = (pos / DC) % N;
        exp_an  = 8'hFF;
        exp_cat = 7'h7F;
        if (slot_t >= BC) begin
            exp_cat = glyph(int'((m_shadow >> (4 * dig)) & 32'hF));
            if (!is_blanked(dig)) exp_an = ~(8'd1 << dig);
        end
        if (at_wrap(pos)) begin
            if (vv) begin
                m_shadow = v;
                m_bz     = bz;
            end else if (m_pend) begin
                m_shadow = m_stage;
                m_bz     = m_stage_bz;
            end
            m_pend = 1'b0;
        end else if (vv) begin
            m_pend = 1'b1;
        end
        if (vv) begin
            m_stage    = v;
            m_stage_bz = bz;
        end
        pos++;
        exp_frame = at_wrap(pos);
    endtask

    task automatic cycle(input logic vv, input logic [31:0] v, input logic bz);
        val_valid_in   = vv;
        val_in         = v;
        blank_zeros_in = bz;
        @(posedge clk_in);
        model_edge(vv, v, bz);
        @(negedge clk_in);
        check_val("an_out", {24'd0, an_out}, {24'd0, exp_an});
        check_val("cat_out", {25'd0, cat_out}, {25'd0, exp_cat});
        check_val("frame_out", {31'd0, frame_out}, {31'd0, exp_frame});
        val_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0);
    endtask

    task automatic idle_to(input int phase);
        while ((pos % FRAME) != phase) cycle(1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] rv;
        rst_n_in       = 1'b0;
        val_in         = '0;
        val_valid_in   = 1'b0;
        blank_zeros_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_val("rst_an", {24'd0, an_out}, 32'hFF);
        check_val("rst_cat", {25'd0, cat_out}, 32'h7F);
        check_val("rst_frame", {31'd0, frame_out}, 32'd0);
        rst_n_in = 1'b1;

        // Scan without suppression, then with, then the zero value.
        cycle(1'b1, 32'h00000123, 1'b0);
        idle(2 * FRAME);
        cycle(1'b1, 32'h00000123, 1'b1);
        idle(2 * FRAME);
        cycle(1'b1, 32'h00000000, 1'b1);
        idle(2 * FRAME);

        // Mid-frame updates must not tear; last strobe wins.
        idle_to(20);
        cycle(1'b1, 32'h00000099, 1'b0);
        idle(10);
        cycle(1'b1, 32'h00000045, 1'b0);
        idle(FRAME + 10);

        // Strobe coincident with the frame pulse goes straight to the display.
        idle_to(FRAME - 1);
        check_val("frame_before_coinc", {31'd0, frame_out}, 32'd1);
        cycle(1'b1, 32'h87654321, 1'b0);
        idle(FRAME);

        cycle(1'b1, 32'h0000000A, 1'b0);
        idle(2 * FRAME);

        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rv = $urandom();
                if ($urandom_range(0, 2) != 0) rv = rv & 32'h0000FFFF & (($urandom_range(0, 1) != 0) ? 32'h00000777 : 32'hFFFFFFFF);
                cycle(1'b1, rv, 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'b0, $urandom(), 1'($urandom_range(0, 1)));
            end
        end

        // Asynchronous reset in the middle of a lit slot.
        cycle(1'b1, 32'h00005678, 1'b1);
        idle_to(FRAME + 3 * DC + 4 - FRAME);
        idle(FRAME);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_val("async_an", {24'd0, an_out}, 32'hFF);
        check_val("async_cat", {25'd0, cat_out}, 32'h7F);
        check_val("async_frame", {31'd0, frame_out}, 32'd0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
        idle(FRAME + 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
